sum8_adder_bank: RTL and testbench
==================================

Name: sum8_adder_bank

Overview:
- Registered 8-bit adder bank with three parallel implementations of A+B+Cin:
  - ripple-carry (index 0)
  - logic-equation / sum-of-products (index 1)
  - carry-lookahead (index 2)
- Each implementation has a transition counter for switching-activity (power) estimation.
- A read port exposes the counters by index.
- Sits in the arithmetic power-analysis harness; results of all three must always agree.

Parameters:
- WIDTH, 8, operand/sum width. Only 8 is required; the lookahead is a 2-level 4-bit CLA for WIDTH=8.
- CNT_W, 32, transition-counter width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid this cycle
- opr_a  input  WIDTH  operand A
- opr_b  input  WIDTH  operand B
- cin  input  1  carry in
- out_valid  output  1  results valid
- sum_rizado  output  WIDTH  ripple-carry sum
- carry_rizado  output  1  ripple-carry carry out
- sum_logico  output  WIDTH  logic-equation sum
- carry_logico  output  1  logic-equation carry out
- sum_look  output  WIDTH  lookahead sum
- carry_look  output  1  lookahead carry out
- mismatch  output  1  sticky: any two adders disagreed
- cnt_sel  input  2  counter index (0 ripple, 1 logico, 2 look)
- cnt_clr  input  1  synchronous clear of all counters
- cnt_data  output  CNT_W  selected counter value (combinational from cnt_sel)

Behaviour:
- Reset (rst_n low, asynchronous): all sums, carries, out_valid, mismatch and counters go to 0. The "previous result" registers used for toggle counting also go to 0.
- Adders:
  - Each adder is purely combinational from opr_a/opr_b/cin.
  - {carry,sum} = opr_a + opr_b + cin, computed modulo 2^(WIDTH+1).
  - Ripple: chain of full adders.
  - Logico: sum_i = a_i^b_i^c_i, with c_{i+1} written as the flattened SOP of g/p terms.
  - Look: group generate/propagate with a lookahead carry unit.
- Latency 1:
  - On a clk edge with in_valid=1, all six result outputs register the new values and out_valid goes to 1 the next cycle.
  - With in_valid=0, results hold and out_valid goes to 0.
- Toggle counting, on each accepted in_valid edge:
  - counter[i] += popcount(new {carry_i,sum_i} XOR previously registered {carry_i,sum_i}). This is 9 bits for WIDTH=8.
  - Counters saturate at 2^CNT_W-1 and never wrap.
- cnt_clr=1 on an edge zeroes all counters and takes priority over a simultaneous increment. Result registers are unaffected.
- mismatch: set on any accepted edge where the three {carry,sum} values are not all equal. Cleared only by reset.
- cnt_sel=3 reads 0.
- Wrap-around: opr_a=FF, opr_b=01, cin=0 gives sum 00, carry 1. opr_a=FF, opr_b=FF, cin=1 gives sum FF, carry 1.
- Reset mid-operation: an in-flight result is discarded; out_valid=0 on release.

Optional Feature:
- Macro TOGGLE_CNT_EN.
- Defined: transition counters, cnt_clr and cnt_data behave as above.
- Undefined:
  - No counter storage is synthesized.
  - cnt_data is tied to 0 and cnt_clr/cnt_sel are ignored.
  - Adder results, out_valid and mismatch are unchanged.

Decomposition:
- Package sum8_pkg holds:
  - WIDTH and CNT_W defaults
  - adder index constants: ADD_RIZADO=0, ADD_LOGICO=1, ADD_LOOK=2, NUM_ADD=3
  - a popcount function for WIDTH+1 bits
- One natural sub-module: sum8_toggle_cnt. It holds the previous-value register, XOR, popcount and saturating counter, and is instantiated three times.
- The three adders are local generate blocks or functions in the top.

Test Plan:
- Reset then A=00,B=00,cin=0 -> all sums 00, carries 0; counters 0,0,0; mismatch 0.
- Then A=00,B=01 -> all sums 01, carry 0; each counter = 1.
- Then A=FF,B=01 -> all sums 00, carry 1 (9'h100 vs 9'h001, 2 toggles); each counter = 3; cnt_sel=0/1/2 reads 3; cnt_sel=3 reads 0.
- A=FF,B=FF,cin=1 -> sum FF, carry 1 from all three; 500 random pairs -> mismatch stays 0 and all three counters are identical.
- cnt_clr asserted together with in_valid -> counters read 0 next cycle; results still update.
- Assert rst_n low mid-stream -> outputs, out_valid and counters 0 immediately. With TOGGLE_CNT_EN undefined, cnt_data is always 0.

Source files
------------

// File: rtl/sum8_pkg.sv
// Shared widths, adder indices and popcount helper for the sum8 adder bank.
package sum8_pkg;

    localparam int WIDTH   = 8;
    localparam int CNT_W   = 32;
    localparam int NUM_ADD = 3;
    localparam int POP_W   = $clog2(WIDTH + 2);

    localparam logic [1:0] ADD_RIZADO = 2'd0;
    localparam logic [1:0] ADD_LOGICO = 2'd1;
    localparam logic [1:0] ADD_LOOK   = 2'd2;

    function automatic logic [POP_W-1:0] popcount(input logic [WIDTH:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/sum8_adder_bank_if.sv
// Operand/result bus and counter read port of the sum8 adder bank.
interface sum8_adder_bank_if;
    import sum8_pkg::*;

    logic             in_valid;
    logic [WIDTH-1:0] opr_a;
    logic [WIDTH-1:0] opr_b;
    logic             cin;
    logic             out_valid;
    logic [WIDTH-1:0] sum_rizado;
    logic             carry_rizado;
    logic [WIDTH-1:0] sum_logico;
    logic             carry_logico;
    logic [WIDTH-1:0] sum_look;
    logic             carry_look;
    logic             mismatch;
    logic [1:0]       cnt_sel;
    logic             cnt_clr;
    logic [CNT_W-1:0] cnt_data;

    modport master (
        output in_valid, opr_a, opr_b, cin, cnt_sel, cnt_clr,
        input  out_valid, sum_rizado, carry_rizado, sum_logico,
        input  carry_logico, sum_look, carry_look, mismatch, cnt_data
    );

    modport slave (
        input  in_valid, opr_a, opr_b, cin, cnt_sel, cnt_clr,
        output out_valid, sum_rizado, carry_rizado, sum_logico,
        output carry_logico, sum_look, carry_look, mismatch, cnt_data
    );

endinterface

// File: rtl/sum8_toggle_cnt.sv
// Transition counter: popcount of result bit flips, saturating accumulate.
module sum8_toggle_cnt
    import sum8_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH:0]   i_val,
    output logic [CNT_W-1:0] o_cnt
);

    localparam int SUM_W = CNT_W + 1;

    logic [WIDTH:0]   r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [SUM_W-1:0] w_sum;

    assign w_sum = {1'b0, r_cnt} + SUM_W'(popcount(i_val ^ r_prev));
    assign o_cnt = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_en) begin
                r_prev <= i_val;
            end
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_en) begin
                r_cnt <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sum8_adder_bank.sv
// Registered ripple / SOP / lookahead adder bank with cross-check.
// Toggle counters are built only when TOGGLE_CNT_EN is defined.
module sum8_adder_bank
    import sum8_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    sum8_adder_bank_if.slave  bus
);

    function automatic logic [WIDTH:0] add_rizado(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             c0
    );
        logic [WIDTH-1:0] s;
        logic             c;
        c = c0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        return {c, s};
    endfunction

    // Each carry is the fully flattened OR of g_j & p_{j+1..i}, plus c0 & p_{0..i}.
    function automatic logic [WIDTH:0] add_logico(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             c0
    );
        logic [WIDTH-1:0] g, p;
        logic [WIDTH:0]   c;
        logic             t;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = c0;
        for (int i = 0; i < WIDTH; i++) begin
            t = c0;
            for (int k = 0; k <= i; k++) t = t & p[k];
            c[i+1] = t;
            for (int j = 0; j <= i; j++) begin
                t = g[j];
                for (int k = j + 1; k <= i; k++) t = t & p[k];
                c[i+1] = c[i+1] | t;
            end
        end
        return {c[WIDTH], p ^ c[WIDTH-1:0]};
    endfunction

    // Returns {G, P, sum[3:0]} of one 4-bit lookahead group.
    function automatic logic [5:0] cla4(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       ci
    );
        logic [3:0] g, p, c;
        logic       gg;
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
        return {gg, &p, p ^ c};
    endfunction

    function automatic logic [WIDTH:0] add_look(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             c0
    );
        logic [5:0] lo, hi;
        logic       c4, c8;
        lo = cla4(a[3:0], b[3:0], c0);
        c4 = lo[5] | (lo[4] & c0);
        hi = cla4(a[7:4], b[7:4], c4);
        c8 = hi[5] | (hi[4] & lo[5]) | (hi[4] & lo[4] & c0);
        return {c8, hi[3:0], lo[3:0]};
    endfunction

    logic [WIDTH:0] w_res [NUM_ADD];
    logic [WIDTH:0] r_res [NUM_ADD];
    logic           w_diff;
    logic           r_valid;
    logic           r_mism;

    assign w_res[ADD_RIZADO] = add_rizado(bus.opr_a, bus.opr_b, bus.cin);
    assign w_res[ADD_LOGICO] = add_logico(bus.opr_a, bus.opr_b, bus.cin);
    assign w_res[ADD_LOOK]   = add_look(bus.opr_a, bus.opr_b, bus.cin);

    assign w_diff = (w_res[0] != w_res[1]) | (w_res[1] != w_res[2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ADD; i++) r_res[i] <= '0;
            r_valid <= 1'b0;
            r_mism  <= 1'b0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                for (int i = 0; i < NUM_ADD; i++) r_res[i] <= w_res[i];
                if (w_diff) r_mism <= 1'b1;
            end
        end
    end

    assign bus.out_valid    = r_valid;
    assign bus.mismatch     = r_mism;
    assign bus.sum_rizado   = r_res[ADD_RIZADO][WIDTH-1:0];
    assign bus.carry_rizado = r_res[ADD_RIZADO][WIDTH];
    assign bus.sum_logico   = r_res[ADD_LOGICO][WIDTH-1:0];
    assign bus.carry_logico = r_res[ADD_LOGICO][WIDTH];
    assign bus.sum_look     = r_res[ADD_LOOK][WIDTH-1:0];
    assign bus.carry_look   = r_res[ADD_LOOK][WIDTH];

`ifdef TOGGLE_CNT_EN
    logic [CNT_W-1:0] w_cnt [NUM_ADD];
    logic [CNT_W-1:0] w_cnt_data;

    for (genvar g = 0; g < NUM_ADD; g++) begin : g_cnt
        sum8_toggle_cnt u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .i_en  (bus.in_valid),
            .i_clr (bus.cnt_clr),
            .i_val (w_res[g]),
            .o_cnt (w_cnt[g])
        );
    end

    always_comb begin
        w_cnt_data = '0;
        unique case (1'b1)
            (bus.cnt_sel == ADD_RIZADO): w_cnt_data = w_cnt[ADD_RIZADO];
            (bus.cnt_sel == ADD_LOGICO): w_cnt_data = w_cnt[ADD_LOGICO];
            (bus.cnt_sel == ADD_LOOK):   w_cnt_data = w_cnt[ADD_LOOK];
            default:                     w_cnt_data = '0;
        endcase
    end

    assign bus.cnt_data = w_cnt_data;
`else
    logic w_unused;
    assign w_unused     = ^{bus.cnt_sel, bus.cnt_clr};
    assign bus.cnt_data = '0;
`endif

endmodule

// File: tb/tb_sum8_adder_bank.sv
// Scoreboard bench for sum8_adder_bank; counter checks follow TOGGLE_CNT_EN.
module tb_sum8_adder_bank;
    import sum8_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sum8_adder_bank_if bus();

    sum8_adder_bank dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [WIDTH:0]   sb [$];
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [WIDTH:0]   m_prev = '0;
    logic [CNT_W-1:0] m_cnt = '0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] cnt_exp();
`ifdef TOGGLE_CNT_EN
        return m_cnt;
`else
        return '0;
`endif
    endfunction

    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic clr,
                         input logic [WIDTH:0] exp);
        logic [CNT_W:0] s;
        @(posedge clk);
        #1;
        bus.opr_a    = a;
        bus.opr_b    = b;
        bus.cin      = c;
        bus.cnt_clr  = clr;
        bus.in_valid = 1'b1;
        sb.push_back(exp);
        s = {1'b0, m_cnt} + (CNT_W + 1)'($countones(exp ^ m_prev));
        if (clr) m_cnt = '0;
        else m_cnt = s[CNT_W] ? '1 : s[CNT_W-1:0];
        m_prev = exp;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.cnt_clr  = 1'b0;
    endtask

    task automatic check_cnts(input string tag);
        for (int s = 0; s < 4; s++) begin
            bus.cnt_sel = 2'(s);
            #1;
            check($sformatf("%s cnt[%0d]", tag, s), bus.cnt_data,
                  (s == 3) ? '0 : cnt_exp());
        end
        bus.cnt_sel = 2'd0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, " out_valid"}, bus.out_valid, 0);
        check({tag, " rizado"}, {bus.carry_rizado, bus.sum_rizado}, 0);
        check({tag, " logico"}, {bus.carry_logico, bus.sum_logico}, 0);
        check({tag, " look"}, {bus.carry_look, bus.sum_look}, 0);
        check({tag, " mismatch"}, bus.mismatch, 0);
    endtask

    // Monitor: every presented result must match the oldest expectation.
    initial begin
        logic [WIDTH:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected out_valid with empty scoreboard");
                end else begin
                    e = sb.pop_front();
                    check("rizado", {bus.carry_rizado, bus.sum_rizado}, e);
                    check("logico", {bus.carry_logico, bus.sum_logico}, e);
                    check("look", {bus.carry_look, bus.sum_look}, e);
                    check("mismatch", bus.mismatch, 0);
                end
            end
        end
    end

    typedef struct {
        logic [7:0]     a;
        logic [7:0]     b;
        logic           c;
        logic [WIDTH:0] r;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [7:0] ra, rb;
        logic       rc;
        vecs[0] = '{8'h00, 8'h00, 1'b0, 9'h000};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 9'h001};
        vecs[2] = '{8'hFF, 8'h01, 1'b0, 9'h100};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
        vecs[4] = '{8'h0F, 8'hF0, 1'b1, 9'h100};
        vecs[5] = '{8'h55, 8'hAA, 1'b0, 9'h0FF};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 9'h100};

        bus.in_valid = 1'b0;
        bus.opr_a    = '0;
        bus.opr_b    = '0;
        bus.cin      = 1'b0;
        bus.cnt_sel  = 2'd0;
        bus.cnt_clr  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        check_cnts("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, vecs[i].r);
            idle();
            check_cnts($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 500; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            drive(ra, rb, rc, 1'b0, {1'b0, ra} + {1'b0, rb} + 9'(rc));
        end
        idle();
        check_cnts("random");
        check("random mismatch", bus.mismatch, 0);

        drive(8'h3C, 8'hC3, 1'b0, 1'b1, 9'h0FF);
        idle();
        check_cnts("clr");
        drive(8'h01, 8'h01, 1'b0, 1'b0, 9'h002);
        idle();
        check_cnts("after clr");

        drive(8'h12, 8'h34, 1'b0, 1'b0, 9'h046);
        idle();
        @(negedge clk);
        #1;
        check("pre-reset sum", bus.sum_look, 8'h46);
        rst_n = 1'b0;
        #1;
        sb.delete();
        m_cnt  = '0;
        m_prev = '0;
        check_zero("midreset");
        check_cnts("midreset");

        @(posedge clk);
        #1;
        bus.opr_a    = 8'h77;
        bus.opr_b    = 8'h11;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_zero("release");
        @(posedge clk);
        #1;
        check("release out_valid", bus.out_valid, 0);

        drive(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100);
        idle();
        check_cnts("recover");

        repeat (3) idle();
        check("scoreboard drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
